// File: rtl/fir_mac_sequencer.sv
// Serial N-tap FIR: one shared MAC stepping through a circular delay line, AXI-Stream in/out.
// Define FIR_SEQ_SAT_EN to saturate the scaled result instead of wrapping it.
module fir_mac_sequencer #(
  parameter int unsigned NTAPS     = 18,
  parameter int unsigned DW        = 16,
  parameter int unsigned CW        = 16,
  parameter int unsigned ACCW      = 40,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          s_axis_data_tvalid,
  output logic          s_axis_data_tready,
  input  logic [DW-1:0] s_axis_data_tdata,
  output logic          m_axis_data_tvalid,
  input  logic          m_axis_data_tready,
  output logic [DW-1:0] m_axis_data_tdata,
  input  logic          coef_wr_en,
  input  logic [4:0]    coef_wr_addr,
  input  logic [CW-1:0] coef_wr_data,
  output logic          coef_wr_ack,
  output logic          busy
);

  localparam int unsigned AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned PW = CW + DW;
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_next;

  logic signed [DW-1:0]   line [NTAPS];
  logic signed [CW-1:0]   coef [NTAPS];
  logic signed [ACCW-1:0] acc, acc_next, acc_sum;
  logic signed [PW-1:0]   prod;
  logic [AW-1:0]          k, k_next, tap, tap_next, wptr, wptr_next;
  logic [DW-1:0]          result, tdata_next;
  logic                   in_fire, coef_fire;

  assign in_fire   = (state == IDLE) && s_axis_data_tvalid;
  assign coef_fire = coef_wr_en && (state == IDLE) && (32'(coef_wr_addr) < NTAPS);

  // One tap per cycle; tap walks backwards from the newest sample with modulo-NTAPS wrap.
  assign prod    = PW'(coef[k]) * PW'(line[tap]);
  assign acc_sum = acc + ACCW'(prod);

`ifdef FIR_SEQ_SAT_EN
  logic signed [ACCW-1:0] shifted;
  assign shifted = acc_sum >>> OUT_SHIFT;

  always_comb begin
    result = shifted[DW-1:0];
    if (shifted[ACCW-1:DW-1] != {(ACCW-DW+1){shifted[ACCW-1]}})
      result = shifted[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end
`else
  assign result = DW'(acc_sum >>> OUT_SHIFT);
`endif

  always_comb begin
    state_next = state;
    acc_next   = acc;
    k_next     = k;
    tap_next   = tap;
    wptr_next  = wptr;
    tdata_next = m_axis_data_tdata;
    unique case (state)
      IDLE: begin
        if (s_axis_data_tvalid) begin
          acc_next   = '0;
          k_next     = '0;
          tap_next   = wptr;
          state_next = MAC;
        end
      end
      MAC: begin
        acc_next = acc_sum;
        k_next   = k + 1'b1;
        tap_next = (tap == '0) ? LAST : tap - 1'b1;
        if (k == LAST) begin
          tdata_next = result;
          state_next = OUT;
        end
      end
      OUT: begin
        if (m_axis_data_tready) begin
          wptr_next  = (wptr == LAST) ? '0 : wptr + 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state              <= IDLE;
      acc                <= '0;
      k                  <= '0;
      tap                <= '0;
      wptr               <= '0;
      s_axis_data_tready <= 1'b1;
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tdata  <= '0;
      coef_wr_ack        <= 1'b0;
      busy               <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        line[AW'(i)] <= '0;
        coef[AW'(i)] <= '0;
      end
    end else begin
      state              <= state_next;
      acc                <= acc_next;
      k                  <= k_next;
      tap                <= tap_next;
      wptr               <= wptr_next;
      m_axis_data_tdata  <= tdata_next;
      s_axis_data_tready <= (state_next == IDLE);
      m_axis_data_tvalid <= (state_next == OUT);
      busy               <= (state_next != IDLE);
      coef_wr_ack        <= coef_fire;
      if (in_fire)   line[wptr] <= s_axis_data_tdata;
      if (coef_fire) coef[AW'(coef_wr_addr)] <= coef_wr_data;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomised bench for fir_mac_sequencer against a direct-form FIR sum over the sample history.
module tb_fir_mac_sequencer;

  localparam int NT = 18;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] s_tdata = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [15:0] m_tdata;
  logic        coef_en = 1'b0;
  logic [4:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        coef_ack;
  logic        busy;

  fir_mac_sequencer dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .s_axis_data_tdata  (s_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .m_axis_data_tdata  (m_tdata),
    .coef_wr_en         (coef_en),
    .coef_wr_addr       (coef_addr),
    .coef_wr_data       (coef_data),
    .coef_wr_ack        (coef_ack),
    .busy               (busy)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;
  int hist[$];
  int coef_m[NT];
  bit busy_m = 1'b0;
  int lat = 0;
  int exp_q = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // y[n] = sum coef[k]*x[n-k], wrapped to 40 bits, shifted by 15, reduced to 16 bits.
  function automatic int model_out();
    longint acc = 0;
    int n = hist.size();
    logic signed [15:0] r;
    for (int k = 0; k < NT; k++)
      if (n - 1 - k >= 0) acc += longint'(coef_m[k]) * longint'(hist[n-1-k]);
    acc = (acc <<< 24) >>> 24;
    acc = acc >>> 15;
`ifdef FIR_SEQ_SAT_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    r = acc[15:0];
    return int'(r);
  endfunction

  task automatic model_clear();
    hist.delete();
    foreach (coef_m[i]) coef_m[i] = 0;
    busy_m = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0; coef_en = 1'b0;
    model_clear();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic write_coef(input int addr, input int data);
    bit ok_m = (addr < NT) && !busy_m;
    coef_en = 1'b1; coef_addr = 5'(addr); coef_data = 16'(data);
    @(negedge aclk);
    coef_en = 1'b0;
    lat++;
    check("coef_ack", coef_ack, ok_m);
    if (ok_m) coef_m[addr] = data;
  endtask

  task automatic push(input int x);
    int n = 0;
    while (!s_tready && n < 50) begin @(negedge aclk); n++; end
    check("in_ready", s_tready, 1);
    s_tvalid = 1'b1; s_tdata = 16'(x);
    @(negedge aclk);
    s_tvalid = 1'b0;
    hist.push_back(x);
    exp_q = model_out();
    busy_m = 1'b1;
    lat = 1;
  endtask

  task automatic pull(input int hold);
    bit bad_ready = 1'b0;
    bit bad_hold = 1'b0;
    logic [15:0] held;
    while (!m_tvalid && lat < 60) begin
      if (s_tready || !busy) bad_ready = 1'b1;
      @(negedge aclk);
      lat++;
    end
    check("latency", lat, NT + 1);
    check("ready_low_while_busy", bad_ready, 0);
    held = m_tdata;
    repeat (hold) begin
      @(negedge aclk);
      if (m_tdata !== held || !m_tvalid || s_tready || !busy) bad_hold = 1'b1;
    end
    if (hold > 0) check("backpressure_hold", bad_hold, 0);
    check("tdata", $signed(m_tdata), exp_q);
    check("busy_at_handshake", busy, 1);
    m_tready = 1'b1;
    @(negedge aclk);
    m_tready = 1'b0;
    busy_m = 1'b0;
    check("tvalid_drop", m_tvalid, 0);
    check("ready_after", s_tready, 1);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_tready", s_tready, 1);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", coef_ack, 0);

    // Zero coefficients give zero output.
    model_clear();
    push(1234); pull(0);
    check("zero_coef_out", $signed(m_tdata), 0);

    // Impulse through the wrap-around, then again after wptr has wrapped.
    do_reset();
    write_coef(3, 16384);
    for (int i = 0; i < 25; i++) begin
      push(i == 0 ? 2000 : 0); pull(0);
      if (i == 3) check("impulse_tap3", exp_q, 1000);
    end
    for (int i = 0; i < 6; i++) begin
      push(i == 0 ? 2000 : 0); pull(0);
    end

    // Backpressure.
    push(-3210); pull(10);

    // Coefficient write rules.
    do_reset();
    push(7);
    write_coef(0, 16384);
    pull(0);
    push(1000); pull(0);
    check("busy_write_dropped", $signed(m_tdata), 0);
    write_coef(0, 16384);
    @(negedge aclk);
    check("ack_one_pulse", coef_ack, 0);
    push(1000); pull(0);
    check("idle_write_used", $signed(m_tdata), 500);
    write_coef(18, 1);

    // Saturation / wrap.
    do_reset();
    for (int a = 0; a < NT; a++) write_coef(a, 32767);
    for (int i = 0; i < NT; i++) begin push(32767); pull(0); end
`ifdef FIR_SEQ_SAT_EN
    check("sat_18th", $signed(m_tdata), 32767);
`else
    check("wrap_18th", $signed(m_tdata), -36);
`endif

    // Randomised traffic with random coefficient writes.
    do_reset();
    for (int a = 0; a < NT; a++) write_coef(a, int'($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0)
        write_coef(int'($urandom_range(0, 23)), int'($urandom_range(0, 65535)) - 32768);
      push(int'($urandom_range(0, 65535)) - 32768);
      if ($urandom_range(0, 3) == 0)
        write_coef(int'($urandom_range(0, 17)), int'($urandom_range(0, 65535)) - 32768);
      pull(int'($urandom_range(0, 3)));
    end

    // Reset in the middle of MAC.
    push(555);
    repeat (6) @(negedge aclk);
    aresetn = 1'b0;
    model_clear();
    #1;
    check("midrst_tvalid", m_tvalid, 0);
    check("midrst_busy", busy, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    seen = 1'b0;
    repeat (25) begin @(negedge aclk); if (m_tvalid) seen = 1'b1; end
    check("midrst_no_output", seen, 0);
    write_coef(0, 16384);
    push(2000); pull(0);
    check("midrst_clean_history", $signed(m_tdata), 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Controller and shared-MAC datapath for a serial N-tap FIR filter with AXI-Stream sample input and output. It accepts one sample, then steps one multiply-accumulate per clock through a circular delay line and a runtime-loadable coefficient bank. It presents a scaled result with full output backpressure. It sits between the sample source and downstream consumers as the low-area replacement for the fully parallel FIR stage, and owns the coefficient configuration port.

## Interface
- NTAPS, 18, number of taps (2..32)
- DW, 16, sample and output width, signed
- CW, 16, coefficient width, signed
- ACCW, 40, accumulator width, signed
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before output

- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_axis_data_tvalid  in  1  input sample valid
- s_axis_data_tready  out  1  high only in IDLE
- s_axis_data_tdata  in  DW  signed input sample
- m_axis_data_tvalid  out  1  result valid, high only in OUT
- m_axis_data_tready  in  1  downstream ready
- m_axis_data_tdata  out  DW  signed filtered result, held stable while tvalid is high
- coef_wr_en  in  1  coefficient write strobe
- coef_wr_addr  in  5  tap index, 0..NTAPS-1
- coef_wr_data  in  CW  signed coefficient
- coef_wr_ack  out  1  one-cycle pulse the cycle after a write is accepted
- busy  out  1  high in MAC and OUT

## Operation
- Reset values:
  - state IDLE; s_axis_data_tready=1; m_axis_data_tvalid=0; m_axis_data_tdata=0.
  - coef_wr_ack=0; busy=0.
  - All delay-line entries, coefficients, accumulator and write pointer wptr are 0.
- IDLE:
  - On s_axis_data_tvalid & tready, write the sample to line[wptr], clear the accumulator and k, then go to MAC.
- MAC (NTAPS cycles, k=0..NTAPS-1):
  - acc += coef[k] * line[(wptr-k) mod NTAPS].
  - Wrap-around is a modulo-NTAPS subtract; NTAPS need not be a power of two.
  - After k=NTAPS-1, latch the output and go to OUT.
- OUT:
  - Hold m_axis_data_tvalid=1 and the data stable until m_axis_data_tready.
  - On the handshake: wptr=(wptr+1) mod NTAPS, go to IDLE.
  - Input is not accepted in the same cycle as the output handshake.
- Arithmetic:
  - The product is CW+DW bits, sign-extended into ACCW.
  - The accumulator wraps silently in ACCW; sizing is the integrator's responsibility.
  - Output = acc >>> OUT_SHIFT, reduced to DW per Configuration.
- Coefficient writes:
  - Accepted only when state is IDLE, including the input-accept cycle; a write in that cycle is used by that sample's computation.
  - Writes while busy=1 are dropped with no ack.
  - Writes with coef_wr_addr >= NTAPS are dropped with no ack.
- Reset mid-operation: any partial result is discarded, m_axis_data_tvalid drops immediately, and all history is cleared.

## Timing
- Cycle 0 is the input handshake.
- MAC runs on cycles 1..NTAPS.
- m_axis_data_tvalid rises at cycle NTAPS+1, which is 19 cycles with defaults.
- Maximum throughput is one sample per NTAPS+2 cycles when m_axis_data_tready is held high.
- busy is high from cycle 1 until the output handshake cycle, inclusive.
- coef_wr_ack is registered and appears one cycle after the accepted write.

## Configuration
- FIR_SEQ_SAT_EN:
  - Defined: the shifted accumulator saturates to [-2^(DW-1), 2^(DW-1)-1].
  - Undefined: the low DW bits of the shifted accumulator are output (two's-complement wrap).

## Test plan
- Reset then a single sample: after reset, tready=1 and m tvalid=0. All coefs 0 and input 1234 -> output 0 exactly 19 cycles after the handshake, and tready=0 from cycle 1 until return to IDLE.
- Impulse response through wrap-around: coef[3]=16384, all others 0. Inputs 2000,0,0,0,0 and 20 more zeros -> outputs 0,0,0,1000,0,...,0. Repeat the impulse after wptr has wrapped and get the same response.
- Backpressure: hold m_axis_data_tready=0 for 10 cycles after tvalid rises -> tdata stable, tready stays 0, and the next sample is accepted only the cycle after the output handshake.
- Coefficient writes:
  - A write of coef[0]=16384 while busy -> no coef_wr_ack, and the next input 1000 yields 0.
  - The same write in IDLE -> ack pulse, and input 1000 yields 500.
  - addr=18 -> no ack.
- Saturation: all coefs 32767 and 18 inputs of 32767 -> the 18th output is 32767 with FIR_SEQ_SAT_EN defined, and -36 (0xFFDC) without it.
- Reset mid-MAC: assert aresetn=0 at cycle 7 -> m tvalid never rises, and the next impulse 2000 with coef[0]=16384 gives output 1000 with no residual history.
